// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: valid/ready in, registered decoded bundle out,
// with an optional one-entry skid register that keeps in_ready off the out_ready path.
module decode_stage #(
    parameter int unsigned PC_W         = 32,
    parameter bit          SKID_EN      = 1'b1,
    parameter bit          RD0_SUPPRESS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_rd_wen,
    output logic [31:0]     out_imm,
    output logic            out_imm_valid,
    output logic [3:0]      out_mem_op,
    output logic            out_mem_unsigned,
    output logic            out_illegal
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_wen;
        logic [XLEN-1:0] imm;
        logic            imm_valid;
        logic [3:0]      mem_op;
        logic            mem_unsigned;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t          state, state_next;
    logic            load_out, load_skid;
    logic            accept, drain;
    logic [31:0]     skid_inst, src_inst;
    logic [PC_W-1:0] skid_pc, src_pc;
    bundle_t         dec, out_q;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign out_valid = (state != EMPTY);
    assign in_ready  = SKID_EN ? (state != TWO) : (out_ready | ~out_valid);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // The output register refills from the skid entry when one is waiting, else from the input.
    assign src_inst = (state == TWO) ? skid_inst : in_inst;
    assign src_pc   = (state == TWO) ? skid_pc : in_pc;

    assign f3     = src_inst[14:12];
    assign f7     = src_inst[31:25];
    assign imm_i  = {{20{src_inst[31]}}, src_inst[31:20]};
    assign imm_s  = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
    assign imm_b  = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
    assign imm_u  = {src_inst[31:12], 12'h000};
    assign imm_j  = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};
    assign imm_sh = {27'd0, src_inst[24:20]};

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // Occupancy control; flush overrides any accept or drain in the same cycle.
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                TWO: if (drain) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        dec           = '0;
        dec.pc        = src_pc;
        dec.opcode    = src_inst[6:0];
        dec.funct3    = f3;
        dec.funct7    = f7;
        dec.rd        = src_inst[11:7];
        dec.rs1       = src_inst[19:15];
        dec.rs2       = src_inst[24:20];
        dec.rd_wen    = 1'b1;
        dec.imm_valid = 1'b1;
        dec.imm       = imm_i;
        case (src_inst[6:0])
            OP_LOAD: begin
                dec.mem_op       = {2'b11, f3[1:0]};
                dec.mem_unsigned = f3[2];
                dec.illegal      = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec.imm     = imm_s;
                dec.rd_wen  = 1'b0;
                dec.mem_op  = {2'b10, f3[1:0]};
                dec.illegal = (f3 > 3'd2);
            end
            OP_BRANCH: begin
                dec.imm     = imm_b;
                dec.rd_wen  = 1'b0;
                dec.illegal = (f3[2:1] == 2'b01);
            end
            OP_LUI, OP_AUIPC: dec.imm = imm_u;
            OP_JAL:           dec.imm = imm_j;
            OP_JALR:          dec.illegal = (f3 != 3'd0);
            OP_IMM: begin
                if (f3 == 3'd1) begin
                    dec.imm     = imm_sh;
                    dec.illegal = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    dec.imm     = imm_sh;
                    dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
                end
            end
            OP_REG: begin
                dec.imm       = '0;
                dec.imm_valid = 1'b0;
                dec.illegal   = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OP_FENCE:  dec.rd_wen = 1'b0;
            OP_SYSTEM: dec.rd_wen = 1'b1;
            default:   dec.illegal = 1'b1;
        endcase
        // Illegal instructions still flow downstream, but carry no side effects.
        if (dec.illegal) begin
            dec.rd_wen       = 1'b0;
            dec.mem_op       = '0;
            dec.mem_unsigned = 1'b0;
            dec.imm_valid    = 1'b0;
            dec.imm          = '0;
        end
        if (RD0_SUPPRESS && (dec.rd == 5'd0)) dec.rd_wen = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            skid_inst <= '0;
            skid_pc   <= '0;
        end else begin
            if (load_out) out_q <= dec;
            if (load_skid) begin
                skid_inst <= in_inst;
                skid_pc   <= in_pc;
            end
        end
    end

    assign out_pc           = out_q.pc;
    assign out_opcode       = out_q.opcode;
    assign out_funct3       = out_q.funct3;
    assign out_funct7       = out_q.funct7;
    assign out_rd           = out_q.rd;
    assign out_rs1          = out_q.rs1;
    assign out_rs2          = out_q.rs2;
    assign out_rd_wen       = out_q.rd_wen;
    assign out_imm          = out_q.imm;
    assign out_imm_valid    = out_q.imm_valid;
    assign out_mem_op       = out_q.mem_op;
    assign out_mem_unsigned = out_q.mem_unsigned;
    assign out_illegal      = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a queue of accepted instructions plus an ISA-level decoder
// predict every visible output each cycle.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_rd_wen, out_imm_valid, out_mem_unsigned, out_illegal;
    logic [3:0]  out_mem_op;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_wen(out_rd_wen),
        .out_imm(out_imm), .out_imm_valid(out_imm_valid), .out_mem_op(out_mem_op),
        .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd, rs1, rs2;
        logic        rd_wen;
        logic [31:0] imm;
        logic        imm_valid;
        logic [3:0]  mem_op;
        logic        mem_unsigned;
        logic        illegal;
    } obs_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    passed = 0;

    // ISA-level decode of one instruction into the bundle the stage should show.
    function automatic obs_t ref_bundle(input item_t it);
        obs_t        e;
        logic [31:0] i;
        logic        legal, wen, immv, uns;
        logic [3:0]  mem;
        int          imm;
        i = it.inst;
        e = '0;
        e.valid = 1'b1; e.pc = it.pc; e.opcode = i[6:0]; e.funct3 = i[14:12]; e.funct7 = i[31:25];
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        legal = 1'b1; wen = 1'b1; immv = 1'b1; uns = 1'b0; mem = 4'd0;
        imm = (i[31] ? -2048 : 0) + int'(i[30:20]);
        case (i[6:0])
            7'h03: begin
                legal = (i[14:12] != 3'd3) && (i[14:12] < 3'd6);
                mem = {2'b11, i[13:12]}; uns = i[14];
            end
            7'h23: begin
                legal = (i[14:12] <= 3'd2); wen = 1'b0; mem = {2'b10, i[13:12]};
                imm = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
            end
            7'h63: begin
                legal = (i[14:12] != 3'd2) && (i[14:12] != 3'd3); wen = 1'b0;
                imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            end
            7'h37, 7'h17: imm = int'(i & 32'hFFFFF000);
            7'h6F: imm = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            7'h67: legal = (i[14:12] == 3'd0);
            7'h13: begin
                if (i[14:12] == 3'd1) begin
                    legal = (i[31:25] == 7'h00); imm = int'(i[24:20]);
                end else if (i[14:12] == 3'd5) begin
                    legal = (i[31:25] == 7'h00) || (i[31:25] == 7'h20); imm = int'(i[24:20]);
                end
            end
            7'h33: begin
                immv = 1'b0; imm = 0;
                legal = (i[31:25] == 7'h00) ||
                        ((i[31:25] == 7'h20) && ((i[14:12] == 3'd0) || (i[14:12] == 3'd5)));
            end
            7'h0F: wen = 1'b0;
            7'h73: wen = 1'b1;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            wen = 1'b0; immv = 1'b0; uns = 1'b0; mem = 4'd0; imm = 0;
        end
        if (i[11:7] == 5'd0) wen = 1'b0;
        e.rd_wen = wen; e.imm = 32'(imm); e.imm_valid = immv;
        e.mem_op = mem; e.mem_unsigned = uns; e.illegal = !legal;
        return e;
    endfunction

    function automatic obs_t ref_obs();
        obs_t e;
        e = (q.size() > 0) ? ref_bundle(q[0]) : '0;
        e.valid = (q.size() > 0);
        e.ready = (q.size() < 2);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = '0;
        o.valid = out_valid;
        o.ready = in_ready;
        if (out_valid) begin
            o.pc = out_pc; o.opcode = out_opcode; o.funct3 = out_funct3; o.funct7 = out_funct7;
            o.rd = out_rd; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd_wen = out_rd_wen;
            o.imm = out_imm; o.imm_valid = out_imm_valid; o.mem_op = out_mem_op;
            o.mem_unsigned = out_mem_unsigned; o.illegal = out_illegal;
        end
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: r[6:0] = 7'h03;  1: r[6:0] = 7'h23;  2: r[6:0] = 7'h63;  3: r[6:0] = 7'h37;
            4: r[6:0] = 7'h17;  5: r[6:0] = 7'h6F;  6: r[6:0] = 7'h67;  7: r[6:0] = 7'h13;
            8: r[6:0] = 7'h33;  9: r[6:0] = 7'h0F; 10: r[6:0] = 7'h73;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 0) r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, return at the next negedge.
    task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic r);
        item_t it;
        logic  acc, drn;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        if (r || fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                it.pc = pc; it.inst = inst;
                q.push_back(it);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        drive(1'b1, 32'h00000013, 32'h40, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        got = observe(); exp = ref_obs();
        checks++;
        if (got !== exp) $display("FAIL reset_obs: got %h want %h", got, exp);
        else passed++;
        checks++;
        if ({out_pc, out_imm, out_illegal, out_mem_op, out_rd_wen} !== '0)
            $display("FAIL reset_data: got pc=%h imm=%h ill=%b mem=%h wen=%b want all zero",
                     out_pc, out_imm, out_illegal, out_mem_op, out_rd_wen);
        else passed++;
    endtask

    task automatic test_imm_formats();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        obs_t        got, exp;
        insts = '{32'hFFF00093, 32'h800000EF, 32'h12345037, 32'hFE000EE3};
        // The last is beq x0,x0,-4.
        imms  = '{32'hFFFFFFFF, 32'hFFF00000, 32'h12345000, 32'hFFFFFFFC};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, insts[k], 32'h1000 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
            checks++;
            if (!out_valid || out_imm !== imms[k])
                $display("FAIL imm_%0d: got valid=%b imm=%h want valid=1 imm=%h", k, out_valid, out_imm, imms[k]);
            else passed++;
            got = observe(); exp = ref_obs();
            checks++;
            if (got !== exp) $display("FAIL imm_obs_%0d: got %h want %h", k, got, exp);
            else passed++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mem_illegal();
        logic [31:0] insts [6];
        logic [6:0]  want  [6];
        logic [6:0]  got;
        // want = {mem_op, mem_unsigned, rd_wen, illegal}
        insts = '{32'h0040C083, 32'h00112223, 32'h00000000, 32'h40001033, 32'h00003003, 32'h00000013};
        want  = '{7'b1100_1_1_0, 7'b1010_0_0_0, 7'b0000_0_0_1, 7'b0000_0_0_1, 7'b0000_0_0_1, 7'b0000_0_0_0};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, insts[k], 32'h2000 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
            got = {out_mem_op, out_mem_unsigned, out_rd_wen, out_illegal};
            checks++;
            if (!out_valid || got !== want[k])
                $display("FAIL memill_%0d: got valid=%b {mem,uns,wen,ill}=%b want 1 %b", k, out_valid, got, want[k]);
            else passed++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, rand_inst(), 32'h3000 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
            got = observe(); exp = ref_obs();
            checks++;
            if (got !== exp || !in_ready) $display("FAIL b2b_%0d: got %h want %h", k, got, exp);
            else passed++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [31:0] drained[$];
        logic [31:0] insts [4];
        obs_t        got, exp, prev;
        logic        ordy, stalled;
        int          idx, cyc;
        for (int k = 0; k < 4; k++) insts[k] = rand_inst();
        idx = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while ((idx < 4 || q.size() > 0) && cyc < 30) begin
            ordy = (cyc >= 3);
            if (out_valid && ordy) drained.push_back(out_pc);
            if (idx < 4) begin
                if (q.size() < 2) begin
                    drive(1'b1, insts[idx], 32'h100 + 32'(idx * 4), ordy, 1'b0, 1'b0);
                    idx++;
                end else begin
                    drive(1'b1, insts[idx], 32'h100 + 32'(idx * 4), ordy, 1'b0, 1'b0);
                end
            end else begin
                drive(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
            end
            got = observe(); exp = ref_obs();
            checks++;
            if (got !== exp) $display("FAIL bp_obs_c%0d: got %h want %h", cyc, got, exp);
            else passed++;
            if (stalled) begin
                checks++;
                if ({got.valid, got[103:0]} !== {prev.valid, prev[103:0]})
                    $display("FAIL bp_stable_c%0d: got %h want %h", cyc, got, prev);
                else passed++;
            end
            if (cyc == 1) begin
                checks++;
                if (in_ready !== 1'b0) $display("FAIL bp_ready_drop: got in_ready=%b want 0", in_ready);
                else passed++;
            end
            stalled = got.valid && !(cyc + 1 >= 3);
            prev = got;
            cyc++;
        end
        if (out_valid && (cyc >= 3)) drained.push_back(out_pc);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cyc >= 30 || drained.size() != 4)
            $display("FAIL bp_count: got %0d bundles in %0d cycles want 4", drained.size(), cyc);
        else passed++;
        for (int k = 0; k < 4 && k < drained.size(); k++) begin
            checks++;
            if (drained[k] !== 32'h100 + 32'(k * 4))
                $display("FAIL bp_order_%0d: got pc=%h want %h", k, drained[k], 32'h100 + 32'(k * 4));
            else passed++;
        end
    endtask

    task automatic fill_two(input logic [31:0] base);
        drive(1'b1, rand_inst(), base, 1'b0, 1'b0, 1'b0);
        drive(1'b1, rand_inst(), base + 32'd4, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        obs_t got, exp;
        fill_two(32'h500);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL flush_full: got valid=%b ready=%b want 1 0", out_valid, in_ready);
        else passed++;
        drive(1'b1, rand_inst(), 32'h508, 1'b1, 1'b1, 1'b0);
        got = observe(); exp = ref_obs();
        checks++;
        if (got !== exp || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_now: got %h want %h", got, exp);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b0) $display("FAIL flush_leak_%0d: got out_valid=%b pc=%h want 0", k, out_valid, out_pc);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        fill_two(32'h600);
        drive(1'b1, rand_inst(), 32'h608, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0)
            $display("FAIL rst_mid: got valid=%b ready=%b imm=%h want 0 1 00000000", out_valid, in_ready, out_imm);
        else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        obs_t        got, exp;
        logic [31:0] pc;
        pc = 32'h8000;
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_inst(), pc, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0), 1'b0);
            pc = pc + 32'd4;
            got = observe(); exp = ref_obs();
            checks++;
            if (got !== exp) $display("FAIL rand_%0d: got %h want %h", k, got, exp);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_imm_formats();
        test_mem_illegal();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
